// File: rtl/sha256_ctrl_pkg.sv
// sha256_ctrl_pkg
// Shared definitions for the SHA-256 round sequencer and its datapath:
//   - state_t    : sequencer state encoding
//   - ROUNDS_DEF : compression rounds per block
//   - RIDX_W     : width of the round index bus
//   - SHA256_IV  : initial hash value H0..H7
//   - SHA256_K   : round constant table, indexed by round_idx
//   - sha256_k() : round-constant lookup helper for the datapath
// Optional feature macro: DOUBLE_HASH_EN (the P2_INIT state is always
// encoded but is only reachable when the macro is defined).
package sha256_ctrl_pkg;

   localparam int ROUNDS_DEF = 64;
   localparam int RIDX_W     = 6;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_BLK = 3'd1,
      LOAD     = 3'd2,
      ROUND    = 3'd3,
      UPDATE   = 3'd4,
      P2_INIT  = 3'd5,
      DONE     = 3'd6
   } state_t;

   localparam logic [31:0] SHA256_IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] SHA256_K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Round constant for the round currently presented on round_idx.
   function automatic logic [31:0] sha256_k(input logic [RIDX_W-1:0] idx);
      return SHA256_K[idx];
   endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// sha256_round_cnt
// Round index counter with synchronous clear (priority) and enable, plus a
// terminal-count flag when the count reaches ROUNDS-1.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : force count to 0 on next edge
//   en         : increment count on next edge
//   cnt        : current round index (registered)
//   tc         : cnt == ROUNDS-1
module sha256_round_cnt
   import sha256_ctrl_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEF
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   output logic [RIDX_W-1:0] cnt,
   output logic              tc
);

   localparam logic [RIDX_W-1:0] TC_VAL = RIDX_W'(ROUNDS - 1);

   // Round index register: clear wins over enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= {RIDX_W{1'b0}};
      end else if (clr) begin
         cnt <= {RIDX_W{1'b0}};
      end else if (en) begin
         cnt <= cnt + RIDX_W'(1);
      end else begin
         cnt <= cnt;
      end
   end

   assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
// Sequencer for one SHA-256 compression core. Accepts message blocks over a
// valid/ready handshake, steps the round datapath through ROUNDS rounds per
// block and strobes the H registers for IV load and accumulate.
// Optional feature macro: DOUBLE_HASH_EN -- after the last block the digest
// is hashed a second time (adds output pass2 and the P2_INIT state).
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : job start pulse, only honoured in IDLE
//   num_blocks  : blocks in job, latched on an accepted start
//   blk_valid   : message block available
//   blk_ready   : block accepted (WAIT_BLK only)
//   w_load      : schedule loads 16 message words
//   init_sel    : working regs load from H (1) or datapath (0)
//   round_en    : advance working regs / schedule one round
//   round_idx   : current round, 0 outside ROUND
//   h_iv_sel    : H regs load the IV (pulse)
//   h_update    : H += a..h (pulse)
//   busy        : controller not IDLE
//   done        : job complete (pulse)
//   pass2       : second hash pass in progress (DOUBLE_HASH_EN only)
// All outputs except w_load are registered decodes of the next state, so
// they line up with the state they describe.
module sha256_round_ctrl
   import sha256_ctrl_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEF,
   parameter int BLK_W  = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [BLK_W-1:0]  num_blocks,
   input  logic              blk_valid,
   output logic              blk_ready,
   output logic              w_load,
   output logic              init_sel,
   output logic              round_en,
   output logic [RIDX_W-1:0] round_idx,
   output logic              h_iv_sel,
   output logic              h_update,
   output logic              busy,
   output logic              done
`ifdef DOUBLE_HASH_EN
   ,
   output logic              pass2
`endif
);

   state_t             state_r;
   state_t             state_nxt_s;
   logic [BLK_W-1:0]   blocks_left_r;
   logic [BLK_W-1:0]   blocks_left_nxt_s;
   logic               cnt_clr_s;
   logic               cnt_en_s;
   logic               cnt_tc_s;

   logic               blk_ready_nxt_s;
   logic               init_sel_nxt_s;
   logic               round_en_nxt_s;
   logic               h_iv_sel_nxt_s;
   logic               h_update_nxt_s;
   logic               busy_nxt_s;
   logic               done_nxt_s;

`ifdef DOUBLE_HASH_EN
   logic               pass2_nxt_s;
   logic               p2_load_r;
   logic               p2_load_nxt_s;
`endif

   // Counter clears whenever the next state leaves ROUND, so it reads 0 in
   // the first ROUND cycle and wraps back to 0 on exit.
   assign cnt_clr_s = (state_nxt_s != ROUND);
   assign cnt_en_s  = (state_r == ROUND);

   sha256_round_cnt #(
      .ROUNDS (ROUNDS)
   ) u_round_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr_s),
      .en    (cnt_en_s),
      .cnt   (round_idx),
      .tc    (cnt_tc_s)
   );

   // State and block-count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         blocks_left_r <= {BLK_W{1'b0}};
      end else begin
         state_r       <= state_nxt_s;
         blocks_left_r <= blocks_left_nxt_s;
      end
   end

   // Next-state and block bookkeeping.
   always_comb begin
      state_nxt_s       = state_r;
      blocks_left_nxt_s = blocks_left_r;
`ifdef DOUBLE_HASH_EN
      pass2_nxt_s       = pass2;
`endif
      case (state_r)
         IDLE: begin
            if (start && (num_blocks != {BLK_W{1'b0}})) begin
               state_nxt_s       = WAIT_BLK;
               blocks_left_nxt_s = num_blocks;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT_BLK: begin
            if (blk_valid) begin
               state_nxt_s = LOAD;
            end else begin
               state_nxt_s = WAIT_BLK;
            end
         end
         LOAD: begin
            state_nxt_s = ROUND;
         end
         ROUND: begin
            if (cnt_tc_s) begin
               state_nxt_s = UPDATE;
            end else begin
               state_nxt_s = ROUND;
            end
         end
         UPDATE: begin
`ifdef DOUBLE_HASH_EN
            if (pass2) begin
               // Second pass has no block count of its own.
               state_nxt_s = DONE;
            end else
`endif
            begin
               blocks_left_nxt_s = blocks_left_r - BLK_W'(1);
               if (blocks_left_r == BLK_W'(1)) begin
`ifdef DOUBLE_HASH_EN
                  state_nxt_s = P2_INIT;
                  pass2_nxt_s = 1'b1;
`else
                  state_nxt_s = DONE;
`endif
               end else begin
                  state_nxt_s = WAIT_BLK;
               end
            end
         end
         P2_INIT: begin
            state_nxt_s = LOAD;
         end
         DONE: begin
            state_nxt_s = IDLE;
`ifdef DOUBLE_HASH_EN
            pass2_nxt_s = 1'b0;
`endif
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Output decode of the next state, captured by the output register below.
   always_comb begin
      blk_ready_nxt_s = (state_nxt_s == WAIT_BLK);
      init_sel_nxt_s  = (state_nxt_s == LOAD);
      round_en_nxt_s  = (state_nxt_s == ROUND);
      h_iv_sel_nxt_s  = ((state_r == IDLE) && (state_nxt_s == WAIT_BLK)) ||
                        (state_nxt_s == P2_INIT);
      h_update_nxt_s  = (state_nxt_s == UPDATE);
      busy_nxt_s      = (state_nxt_s != IDLE);
      done_nxt_s      = (state_nxt_s == DONE);
`ifdef DOUBLE_HASH_EN
      p2_load_nxt_s   = (state_nxt_s == P2_INIT);
`endif
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_ready <= 1'b0;
         init_sel  <= 1'b0;
         round_en  <= 1'b0;
         h_iv_sel  <= 1'b0;
         h_update  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef DOUBLE_HASH_EN
         pass2     <= 1'b0;
         p2_load_r <= 1'b0;
`endif
      end else begin
         blk_ready <= blk_ready_nxt_s;
         init_sel  <= init_sel_nxt_s;
         round_en  <= round_en_nxt_s;
         h_iv_sel  <= h_iv_sel_nxt_s;
         h_update  <= h_update_nxt_s;
         busy      <= busy_nxt_s;
         done      <= done_nxt_s;
`ifdef DOUBLE_HASH_EN
         pass2     <= pass2_nxt_s;
         p2_load_r <= p2_load_nxt_s;
`endif
      end
   end

`ifdef DOUBLE_HASH_EN
   // In P2_INIT the schedule captures the padded first-pass digest from H.
   assign w_load = (blk_valid & blk_ready) | p2_load_r;
`else
   assign w_load = blk_valid & blk_ready;
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl
// Directed bench for sha256_round_ctrl. Every strobe the DUT raises is
// matched, in order, against a queue of expected {kind, cycle, round_idx}
// records that the stimulus pushes when it launches a job.
module tb_sha256_round_ctrl;

   localparam int          ROUNDS  = 64;
   localparam logic [3:0]  EV_IV   = 4'd0;
   localparam logic [3:0]  EV_WL   = 4'd1;
   localparam logic [3:0]  EV_INIT = 4'd2;
   localparam logic [3:0]  EV_RND  = 4'd3;
   localparam logic [3:0]  EV_UPD  = 4'd4;
   localparam logic [3:0]  EV_DONE = 4'd5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] num_blocks;
   logic       blk_valid;
   logic       blk_ready;
   logic       w_load;
   logic       init_sel;
   logic       round_en;
   logic [5:0] round_idx;
   logic       h_iv_sel;
   logic       h_update;
   logic       busy;
   logic       done;
`ifdef DOUBLE_HASH_EN
   logic       pass2;
`endif

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [25:0] sb[$];

   sha256_round_ctrl #(.ROUNDS(ROUNDS), .BLK_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_blocks (num_blocks),
      .blk_valid  (blk_valid),
      .blk_ready  (blk_ready),
      .w_load     (w_load),
      .init_sel   (init_sel),
      .round_en   (round_en),
      .round_idx  (round_idx),
      .h_iv_sel   (h_iv_sel),
      .h_update   (h_update),
      .busy       (busy),
      .done       (done)
`ifdef DOUBLE_HASH_EN
      ,
      .pass2      (pass2)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [25:0] ev(input logic [3:0] kind, input int c, input logic [5:0] idx);
      logic [15:0] c16;
      c16 = c[15:0];
      return {kind, c16, idx};
   endfunction

   task automatic check_ev(input logic [25:0] got);
      logic [25:0] exp;
      n_cmp++;
      if (sb.size() == 0) exp = '1;
      else                exp = sb.pop_front();
      assert (got === exp) else begin
         n_err++;
         $error("FAIL event observed kind=%0d cyc=%0d idx=%0d expected kind=%0d cyc=%0d idx=%0d",
                got[25:22], got[21:6], got[5:0], exp[25:22], exp[21:6], exp[5:0]);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance to #1 after the edge that starts cycle t (bounded).
   task automatic to_cycle(input int t);
      int guard = 0;
      while (cyc < t && guard < 5000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (cyc != t) begin
         n_cmp++;
         n_err++;
         $error("FAIL to_cycle observed=%0d expected=%0d", cyc, t);
      end
   endtask

   // Block whose handshake happens in cycle w; nr rounds expected.
   task automatic push_block(input int w, input int nr);
      sb.push_back(ev(EV_WL, w, 6'd0));
      sb.push_back(ev(EV_INIT, w + 1, 6'd0));
      for (int i = 0; i < nr; i++) sb.push_back(ev(EV_RND, w + 2 + i, i[5:0]));
      if (nr == ROUNDS) sb.push_back(ev(EV_UPD, w + 66, 6'd0));
   endtask

   // Events after the final block's UPDATE in cycle u; dc = done cycle.
   task automatic push_tail(input int u, output int dc);
`ifdef DOUBLE_HASH_EN
      sb.push_back(ev(EV_IV, u + 1, 6'd0));
      push_block(u + 1, ROUNDS);
      sb.push_back(ev(EV_DONE, u + 68, 6'd0));
      dc = u + 68;
`else
      sb.push_back(ev(EV_DONE, u + 1, 6'd0));
      dc = u + 1;
`endif
   endtask

   // One-block job with blk_valid held high; optionally pokes start mid-ROUND.
   task automatic run_single(input bit poke);
      int c0;
      int dc;
      c0 = cyc;
      num_blocks = 4'd1;
      start = 1'b1;
      sb.push_back(ev(EV_IV, c0 + 1, 6'd0));
      push_block(c0 + 1, ROUNDS);
      push_tail(c0 + 67, dc);
      to_cycle(c0 + 1);
      start = 1'b0;
      chk("busy_c1", {31'd0, busy}, 32'd1);
      chk("ready_c1", {31'd0, blk_ready}, 32'd1);
      if (poke) begin
         to_cycle(c0 + 30);
         start = 1'b1;
         num_blocks = 4'd5;
         to_cycle(c0 + 31);
         start = 1'b0;
         num_blocks = 4'd1;
         chk("idx_c31", {26'd0, round_idx}, 32'd28);
      end
      to_cycle(c0 + 67);
      chk("ready_upd", {31'd0, blk_ready}, 32'd0);
`ifdef DOUBLE_HASH_EN
      chk("pass2_c67", {31'd0, pass2}, 32'd0);
      to_cycle(c0 + 68);
      chk("pass2_c68", {31'd0, pass2}, 32'd1);
`endif
      to_cycle(dc);
      chk("busy_done", {31'd0, busy}, 32'd1);
`ifdef DOUBLE_HASH_EN
      chk("pass2_done", {31'd0, pass2}, 32'd1);
`endif
      to_cycle(dc + 1);
      chk("busy_after", {31'd0, busy}, 32'd0);
`ifdef DOUBLE_HASH_EN
      chk("pass2_after", {31'd0, pass2}, 32'd0);
`endif
   endtask

   // Strobe monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (h_iv_sel === 1'b1) check_ev(ev(EV_IV,   cyc, round_idx));
      if (w_load   === 1'b1) check_ev(ev(EV_WL,   cyc, round_idx));
      if (init_sel === 1'b1) check_ev(ev(EV_INIT, cyc, round_idx));
      if (round_en === 1'b1) check_ev(ev(EV_RND,  cyc, round_idx));
      if (h_update === 1'b1) check_ev(ev(EV_UPD,  cyc, round_idx));
      if (done     === 1'b1) check_ev(ev(EV_DONE, cyc, round_idx));
   end

   initial begin
      int c0;
      int w;
      int hs;
      int u;
      int dc;
      rst_n = 1'b0;
      start = 1'b0;
      num_blocks = 4'd0;
      blk_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, blk_ready}, 32'd0);
      chk("rst_idx", {26'd0, round_idx}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      to_cycle(cyc + 2);

      // Single block, zero-wait, with an ignored start during ROUND
      blk_valid = 1'b1;
      run_single(1'b1);

      // start with num_blocks = 0 is ignored
      to_cycle(cyc + 2);
      c0 = cyc;
      num_blocks = 4'd0;
      start = 1'b1;
      to_cycle(c0 + 1);
      start = 1'b0;
      chk("nb0_busy", {31'd0, busy}, 32'd0);
      chk("nb0_ready", {31'd0, blk_ready}, 32'd0);
      to_cycle(c0 + 3);
      chk("nb0_busy2", {31'd0, busy}, 32'd0);

      // Three blocks, blk_valid arriving 5 cycles into each WAIT_BLK
      blk_valid = 1'b0;
      c0 = cyc;
      num_blocks = 4'd3;
      start = 1'b1;
      sb.push_back(ev(EV_IV, c0 + 1, 6'd0));
      w = c0 + 1;
      u = 0;
      for (int b = 0; b < 3; b++) begin
         hs = w + 5;
         push_block(hs, ROUNDS);
         to_cycle(w + 2);
         start = 1'b0;
         chk("mb_ready_wait", {31'd0, blk_ready}, 32'd1);
         chk("mb_wload_wait", {31'd0, w_load}, 32'd0);
         to_cycle(hs);
         blk_valid = 1'b1;
         to_cycle(hs + 1);
         blk_valid = 1'b0;
         chk("mb_ready_load", {31'd0, blk_ready}, 32'd0);
         u = hs + 66;
         w = u + 1;
      end
      push_tail(u, dc);
      to_cycle(dc + 1);
      chk("mb_busy_end", {31'd0, busy}, 32'd0);

      // Asynchronous reset at round_idx = 30, then a clean job
      blk_valid = 1'b1;
      to_cycle(cyc + 2);
      c0 = cyc;
      num_blocks = 4'd2;
      start = 1'b1;
      sb.push_back(ev(EV_IV, c0 + 1, 6'd0));
      push_block(c0 + 1, 30);
      to_cycle(c0 + 1);
      start = 1'b0;
      to_cycle(c0 + 33);
      chk("abort_idx30", {26'd0, round_idx}, 32'd30);
      rst_n = 1'b0;
      #1;
      chk("abort_round_en", {31'd0, round_en}, 32'd0);
      chk("abort_idx", {26'd0, round_idx}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_wload", {31'd0, w_load}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_sb_empty", sb.size(), 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      to_cycle(cyc + 2);
      run_single(1'b0);

      to_cycle(cyc + 5);
      chk("final_sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
